// File: rtl/mips_pipe_pkg.sv
// Shared constants and control-bundle types for the 16-bit MIPS pipeline registers.
package mips_pipe_pkg;

  localparam int unsigned MIPS_ALUOP_W = 2;
  localparam int unsigned MIPS_REG_AW  = 3;

  // ALU operation classes decoded by the EX-stage ALU control
  typedef enum logic [MIPS_ALUOP_W-1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_RTYPE = 2'd2,
    ALUOP_LOGIC = 2'd3
  } aluop_e;

  // Single-bit control flags carried alongside the instruction
  typedef struct packed {
    logic alu_src;
    logic reg_dest;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic mem_to_reg;
    logic reg_write;
  } ctrl_flags_t;

  // A bubble carries no side effects: every flag low, ALUOp at its zero encoding
  localparam ctrl_flags_t CTRL_NOP  = '0;
  localparam aluop_e      ALUOP_NOP = ALUOP_ADD;

endpackage

// File: rtl/id_ex_sat_cnt.sv
// Saturating event counter with synchronous clear; stops at all-ones.
module id_ex_sat_cnt
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, clear dominates
  always_ff @(negedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, stall hold, flush-to-bubble and
// source register-ID capture for hazard detection. Define ID_EX_PERF_CNT_EN to enable the
// stall and bubble performance counters; otherwise both counter ports read zero.
module id_ex_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_AW  = MIPS_REG_AW,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ALUOP_W = MIPS_ALUOP_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_PC_plus_two,
  input  logic [NUM_SRC*DATA_W-1:0]   in_Read_data,
  input  logic [NUM_SRC*REG_AW-1:0]   in_rs,
  input  logic [DATA_W-1:0]           in_immediate,
  input  logic [REG_AW-1:0]           in_rt,
  input  logic [REG_AW-1:0]           in_rd,
  input  logic                        in_ALU_Src,
  input  logic                        in_RegDest,
  input  logic                        in_MemRead,
  input  logic                        in_MemWrite,
  input  logic                        in_Branch,
  input  logic                        in_MemtoReg,
  input  logic                        in_RegWrite,
  input  logic [ALUOP_W-1:0]          in_ALUOp,
  input  logic                        out_ready,
  output logic                        O_valid,
  output logic [DATA_W-1:0]           O_PC_plus_two,
  output logic [NUM_SRC*DATA_W-1:0]   O_Read_data,
  output logic [NUM_SRC*REG_AW-1:0]   O_rs,
  output logic [DATA_W-1:0]           O_immediate,
  output logic [REG_AW-1:0]           O_rt,
  output logic [REG_AW-1:0]           O_rd,
  output logic                        O_ALU_Src,
  output logic                        O_RegDest,
  output logic                        O_MemRead,
  output logic                        O_MemWrite,
  output logic                        O_Branch,
  output logic                        O_MemtoReg,
  output logic                        O_RegWrite,
  output logic [ALUOP_W-1:0]          O_ALUOp,
  output logic [CNT_W-1:0]            O_stall_cnt,
  output logic [CNT_W-1:0]            O_bubble_cnt
);

  logic                      valid_q, valid_d;
  logic [DATA_W-1:0]         pc_q, pc_d;
  logic [NUM_SRC*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_SRC*REG_AW-1:0] rs_q, rs_d;
  logic [DATA_W-1:0]         imm_q, imm_d;
  logic [REG_AW-1:0]         rt_q, rt_d;
  logic [REG_AW-1:0]         rd_q, rd_d;
  ctrl_flags_t               ctrl_q, ctrl_d;
  logic [ALUOP_W-1:0]        aluop_q, aluop_d;

  ctrl_flags_t               ctrl_in_c;
  logic                      load_c;
  logic                      drain_c;

  // A flushed slot always frees the register, so the upstream never stalls on a squash
  assign in_ready  = flush | ~valid_q | out_ready;
  assign load_c    = in_valid & in_ready;
  assign drain_c   = valid_q & out_ready & ~in_valid;

  assign ctrl_in_c = '{alu_src:    in_ALU_Src,
                       reg_dest:   in_RegDest,
                       mem_read:   in_MemRead,
                       mem_write:  in_MemWrite,
                       branch:     in_Branch,
                       mem_to_reg: in_MemtoReg,
                       reg_write:  in_RegWrite};

  // Next state: flush > load > drain > hold; bubbles keep datapath fields, clear control
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    rs_d    = rs_q;
    imm_d   = imm_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      aluop_d = ALUOP_W'(ALUOP_NOP);
    end else if (load_c) begin
      valid_d = 1'b1;
      pc_d    = in_PC_plus_two;
      rdata_d = in_Read_data;
      rs_d    = in_rs;
      imm_d   = in_immediate;
      rt_d    = in_rt;
      rd_d    = in_rd;
      ctrl_d  = ctrl_in_c;
      aluop_d = in_ALUOp;
    end else if (drain_c) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      aluop_d = ALUOP_W'(ALUOP_NOP);
    end
  end

  // Pipeline register; reset clears everything and wins over any concurrent request
  always_ff @(negedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rdata_q <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= CTRL_NOP;
      aluop_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      aluop_q <= aluop_d;
    end
  end

  assign O_valid       = valid_q;
  assign O_PC_plus_two = pc_q;
  assign O_Read_data   = rdata_q;
  assign O_rs          = rs_q;
  assign O_immediate   = imm_q;
  assign O_rt          = rt_q;
  assign O_rd          = rd_q;
  assign O_ALU_Src     = ctrl_q.alu_src;
  assign O_RegDest     = ctrl_q.reg_dest;
  assign O_MemRead     = ctrl_q.mem_read;
  assign O_MemWrite    = ctrl_q.mem_write;
  assign O_Branch      = ctrl_q.branch;
  assign O_MemtoReg    = ctrl_q.mem_to_reg;
  assign O_RegWrite    = ctrl_q.reg_write;
  assign O_ALUOp       = aluop_q;

`ifdef ID_EX_PERF_CNT_EN
  logic stall_inc_c;
  logic bubble_inc_c;

  // Stall: a valid instruction is held back this edge; bubble: slot is empty after this edge
  assign stall_inc_c  = valid_q & ~out_ready;
  assign bubble_inc_c = ~valid_d;

  id_ex_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (stall_inc_c),
    .cnt_o (O_stall_cnt)
  );

  id_ex_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (bubble_inc_c),
    .cnt_o (O_bubble_cnt)
  );
`else
  assign O_stall_cnt  = '0;
  assign O_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a default-width instance and a 32-bit/3-channel/2-bit-counter
// instance share control stimulus and are checked against a behavioural model.
module tb_id_ex_pipe_reg;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 3;
  localparam int unsigned NS  = 2;
  localparam int unsigned OW  = 2;
  localparam int unsigned CW  = 16;
  localparam int unsigned WDW = 32;
  localparam int unsigned WNS = 3;
  localparam int unsigned WCW = 2;
`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int MAX_CNT  = (1 << CW) - 1;
  localparam int MAX_WCNT = (1 << WCW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus
  logic              rst, flush, in_valid, out_ready;
  logic [DW-1:0]     pc, imm;
  logic [NS*DW-1:0]  rdata;
  logic [NS*AW-1:0]  rs;
  logic [AW-1:0]     rt, rd;
  logic [6:0]        cin;
  logic [OW-1:0]     aluop;
  logic [WDW-1:0]    wpc, wimm;
  logic [WDW-1:0]    wch [WNS];
  logic [WNS*WDW-1:0] wrdata;
  logic [WNS*AW-1:0] wrs;

  assign wrdata = {wch[2], wch[1], wch[0]};

  // Default-instance outputs
  logic              o_ready, o_valid;
  logic [DW-1:0]     o_pc, o_imm;
  logic [NS*DW-1:0]  o_rdata;
  logic [NS*AW-1:0]  o_rs;
  logic [AW-1:0]     o_rt, o_rd;
  logic              o_as, o_rdst, o_mr, o_mw, o_br, o_m2r, o_rw;
  logic [OW-1:0]     o_aluop;
  logic [CW-1:0]     o_stall, o_bubble;
  logic [6:0]        o_ctrl;
  assign o_ctrl = {o_as, o_rdst, o_mr, o_mw, o_br, o_m2r, o_rw};

  // Wide-instance outputs
  logic              w_ready, w_valid;
  logic [WDW-1:0]    w_pc, w_imm;
  logic [WNS*WDW-1:0] w_rdata;
  logic [WNS*AW-1:0] w_rs;
  logic [AW-1:0]     w_rt, w_rd;
  logic              w_as, w_rdst, w_mr, w_mw, w_br, w_m2r, w_rw;
  logic [OW-1:0]     w_aluop;
  logic [WCW-1:0]    w_stall, w_bubble;
  logic [6:0]        w_ctrl;
  assign w_ctrl = {w_as, w_rdst, w_mr, w_mw, w_br, w_m2r, w_rw};

  id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .ALUOP_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ready),
    .in_PC_plus_two(pc), .in_Read_data(rdata), .in_rs(rs), .in_immediate(imm),
    .in_rt(rt), .in_rd(rd),
    .in_ALU_Src(cin[6]), .in_RegDest(cin[5]), .in_MemRead(cin[4]), .in_MemWrite(cin[3]),
    .in_Branch(cin[2]), .in_MemtoReg(cin[1]), .in_RegWrite(cin[0]), .in_ALUOp(aluop),
    .out_ready(out_ready), .O_valid(o_valid), .O_PC_plus_two(o_pc), .O_Read_data(o_rdata),
    .O_rs(o_rs), .O_immediate(o_imm), .O_rt(o_rt), .O_rd(o_rd),
    .O_ALU_Src(o_as), .O_RegDest(o_rdst), .O_MemRead(o_mr), .O_MemWrite(o_mw),
    .O_Branch(o_br), .O_MemtoReg(o_m2r), .O_RegWrite(o_rw), .O_ALUOp(o_aluop),
    .O_stall_cnt(o_stall), .O_bubble_cnt(o_bubble)
  );

  id_ex_pipe_reg #(.DATA_W(WDW), .REG_AW(AW), .NUM_SRC(WNS), .ALUOP_W(OW), .CNT_W(WCW)) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_ready),
    .in_PC_plus_two(wpc), .in_Read_data(wrdata), .in_rs(wrs), .in_immediate(wimm),
    .in_rt(rt), .in_rd(rd),
    .in_ALU_Src(cin[6]), .in_RegDest(cin[5]), .in_MemRead(cin[4]), .in_MemWrite(cin[3]),
    .in_Branch(cin[2]), .in_MemtoReg(cin[1]), .in_RegWrite(cin[0]), .in_ALUOp(aluop),
    .out_ready(out_ready), .O_valid(w_valid), .O_PC_plus_two(w_pc), .O_Read_data(w_rdata),
    .O_rs(w_rs), .O_immediate(w_imm), .O_rt(w_rt), .O_rd(w_rd),
    .O_ALU_Src(w_as), .O_RegDest(w_rdst), .O_MemRead(w_mr), .O_MemWrite(w_mw),
    .O_Branch(w_br), .O_MemtoReg(w_m2r), .O_RegWrite(w_rw), .O_ALUOp(w_aluop),
    .O_stall_cnt(w_stall), .O_bubble_cnt(w_bubble)
  );

  // Reference model state: what the held slot should contain
  logic              m_valid;
  logic [DW-1:0]     m_pc, m_imm;
  logic [NS*DW-1:0]  m_rdata;
  logic [NS*AW-1:0]  m_rs;
  logic [AW-1:0]     m_rt, m_rd;
  logic [6:0]        m_ctrl;
  logic [OW-1:0]     m_aluop;
  logic [WDW-1:0]    m_wpc, m_wimm;
  logic [WDW-1:0]    m_wch [WNS];
  logic [WNS*AW-1:0] m_wrs;
  int                m_stall, m_bubble, m_wstall, m_wbubble;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one negedge of the behavioural rules to the model
  task automatic model_edge();
    logic ready;
    ready = flush || !m_valid || out_ready;
    if (rst) begin
      m_valid = 1'b0; m_pc = '0; m_imm = '0; m_rdata = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      m_ctrl = '0; m_aluop = '0; m_wpc = '0; m_wimm = '0; m_wrs = '0;
      for (int i = 0; i < WNS; i++) m_wch[i] = '0;
      m_stall = 0; m_bubble = 0; m_wstall = 0; m_wbubble = 0;
    end else begin
      if (m_valid && !out_ready) begin
        m_stall  = sat_inc(m_stall, MAX_CNT);
        m_wstall = sat_inc(m_wstall, MAX_WCNT);
      end
      if (flush) begin
        m_valid = 1'b0; m_ctrl = '0; m_aluop = '0;
      end else if (in_valid && ready) begin
        m_valid = 1'b1; m_pc = pc; m_imm = imm; m_rdata = rdata; m_rs = rs; m_rt = rt; m_rd = rd;
        m_ctrl = cin; m_aluop = aluop; m_wpc = wpc; m_wimm = wimm; m_wrs = wrs;
        for (int i = 0; i < WNS; i++) m_wch[i] = wch[i];
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0; m_ctrl = '0; m_aluop = '0;
      end
      if (!m_valid) begin
        m_bubble  = sat_inc(m_bubble, MAX_CNT);
        m_wbubble = sat_inc(m_wbubble, MAX_WCNT);
      end
    end
  endtask

  task automatic check_all();
    logic exp_ready;
    exp_ready = flush || !m_valid || out_ready;
    chk("valid",     64'(o_valid),  64'(m_valid));
    chk("in_ready",  64'(o_ready),  64'(exp_ready));
    chk("pc",        64'(o_pc),     64'(m_pc));
    chk("rdata",     64'(o_rdata),  64'(m_rdata));
    chk("rs",        64'(o_rs),     64'(m_rs));
    chk("imm",       64'(o_imm),    64'(m_imm));
    chk("rt",        64'(o_rt),     64'(m_rt));
    chk("rd",        64'(o_rd),     64'(m_rd));
    chk("ctrl",      64'(o_ctrl),   64'(m_ctrl));
    chk("aluop",     64'(o_aluop),  64'(m_aluop));
    chk("stall",     64'(o_stall),  PERF ? 64'(m_stall) : 64'(0));
    chk("bubble",    64'(o_bubble), PERF ? 64'(m_bubble) : 64'(0));
    chk("w_valid",   64'(w_valid),  64'(m_valid));
    chk("w_ready",   64'(w_ready),  64'(exp_ready));
    chk("w_pc",      64'(w_pc),     64'(m_wpc));
    for (int i = 0; i < WNS; i++) chk($sformatf("w_ch%0d", i), 64'(w_rdata[i*WDW +: WDW]), 64'(m_wch[i]));
    chk("w_rs",      64'(w_rs),     64'(m_wrs));
    chk("w_imm",     64'(w_imm),    64'(m_wimm));
    chk("w_rt",      64'(w_rt),     64'(m_rt));
    chk("w_rd",      64'(w_rd),     64'(m_rd));
    chk("w_ctrl",    64'(w_ctrl),   64'(m_ctrl));
    chk("w_aluop",   64'(w_aluop),  64'(m_aluop));
    chk("w_stall",   64'(w_stall),  PERF ? 64'(m_wstall) : 64'(0));
    chk("w_bubble",  64'(w_bubble), PERF ? 64'(m_wbubble) : 64'(0));
  endtask

  task automatic set_rand();
    pc    = 16'($urandom);
    imm   = 16'($urandom);
    rdata = {16'($urandom), 16'($urandom)};
    rs    = 6'($urandom);
    rt    = 3'($urandom);
    rd    = 3'($urandom);
    cin   = 7'($urandom);
    aluop = 2'($urandom);
    wpc   = $urandom;
    wimm  = $urandom;
    wrs   = 9'($urandom);
    for (int i = 0; i < WNS; i++) wch[i] = $urandom;
  endtask

  // One active (negative) edge, then sample on the following positive edge
  task automatic step();
    model_edge();
    @(negedge clk);
    @(posedge clk);
    check_all();
  endtask

  logic [DW-1:0] held_pc, held_imm;

  initial begin
    set_rand();
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0; rst = 1'b1;

    // Reset for two edges with random inputs
    step();
    set_rand(); flush = 1'($urandom); in_valid = 1'($urandom);
    step();
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_pc",    64'(o_pc),    64'(0));
    chk("rst_ctrl",  64'(o_ctrl),  64'(0));

    // Back-to-back loads, one instruction per edge
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_rand(); pc = 16'(16'h0010 + 2 * k);
      step();
      chk("b2b_pc",    64'(o_pc),     64'(16'h0010 + 2 * k));
      chk("b2b_valid", 64'(o_valid),  64'(1));
      chk("b2b_bub",   64'(o_bubble), 64'(0));
    end

    // Load MemRead+RegWrite then stall for three edges
    set_rand(); cin = 7'b001_0001; held_pc = pc; held_imm = imm;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_rand(); in_valid = 1'b1;
      step();
    end
    chk("stall_pc",    64'(o_pc),    64'(held_pc));
    chk("stall_ctrl",  64'(o_ctrl),  64'(7'b001_0001));
    chk("stall_rdy",   64'(o_ready), 64'(0));
    chk("stall_cnt",   64'(o_stall), PERF ? 64'(3) : 64'(0));
    chk("stall_wcnt",  64'(w_stall), PERF ? 64'(3) : 64'(0));

    // Flush with a concurrent valid instruction while holding
    set_rand(); flush = 1'b1; in_valid = 1'b1;
    step();
    chk("flush_valid", 64'(o_valid),  64'(0));
    chk("flush_ctrl",  64'(o_ctrl),   64'(0));
    chk("flush_aluop", 64'(o_aluop),  64'(0));
    chk("flush_imm",   64'(o_imm),    64'(held_imm));
    chk("flush_rdy",   64'(o_ready),  64'(1));
    chk("flush_bub",   64'(o_bubble), PERF ? 64'(1) : 64'(0));

    // Reset, flush and valid together in the middle of a stall
    flush = 1'b0; out_ready = 1'b1; set_rand(); cin = 7'h7f;
    step();
    out_ready = 1'b0; set_rand();
    step();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; set_rand();
    step();
    chk("rstmix_valid", 64'(o_valid),  64'(0));
    chk("rstmix_pc",    64'(o_pc),     64'(0));
    chk("rstmix_ctrl",  64'(o_ctrl),   64'(0));
    chk("rstmix_stall", 64'(o_stall),  64'(0));
    chk("rstmix_bub",   64'(o_bubble), 64'(0));

    // Five stall edges: wide instance saturates its 2-bit counter
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; set_rand();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_rand();
      step();
    end
    chk("sat_stall",  64'(o_stall), PERF ? 64'(5) : 64'(0));
    chk("sat_wstall", 64'(w_stall), PERF ? 64'(3) : 64'(0));

    // Channel packing on the wide instance
    out_ready = 1'b1; set_rand();
    wch[0] = 32'hAAAA5555; wch[1] = 32'h12345678; wch[2] = 32'hDEADBEEF;
    step();
    chk("pack_ch0", 64'(w_rdata[31:0]),  64'(32'hAAAA5555));
    chk("pack_ch1", 64'(w_rdata[63:32]), 64'(32'h12345678));
    chk("pack_ch2", 64'(w_rdata[95:64]), 64'(32'hDEADBEEF));

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      set_rand();
      rst       = ($urandom % 40) == 0;
      flush     = ($urandom % 8) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
